// File: rtl/wbx_pkg.sv
// Shared encodings for the writeback_ext stage: result source, load size and FSM state.
package wbx_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_LINK = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } load_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/wbx_load_align.sv
// Sub-word load formatter: little-endian lane select plus sign/zero extension.
module wbx_load_align
  import wbx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       offset_i,
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset_i)
      2'd0:    byte_lane = data_i[7:0];
      2'd1:    byte_lane = data_i[15:8];
      2'd2:    byte_lane = data_i[23:16];
      default: byte_lane = data_i[31:24];
    endcase
    half_lane = offset_i[1] ? data_i[31:16] : data_i[15:0];
    case (size_i)
      LD_BYTE: data_o = {{(WIDTH-8){~uns_i & byte_lane[7]}}, byte_lane};
      LD_HALF: data_o = {{(WIDTH-16){~uns_i & half_lane[15]}}, half_lane};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/writeback_ext.sv
// M->W pipeline register with load-stall FSM, timeout watchdog and result select.
// Optional sub-word load formatting is enabled by defining WBX_SUBWORD_LOAD_EN.
//   state   | meaning
//   ST_IDLE | no load waiting on memory data
//   ST_WAIT | load stalled; count_q = stall cycles so far
module writeback_ext
  import wbx_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic             WBX_CLK,
  input  logic             WBX_RST,
  input  logic [WIDTH-1:0] WBX_AluOutM,
  input  logic [WIDTH-1:0] WBX_ReadDataM,
  input  logic             WBX_ReadValidM,
  input  logic [WIDTH-1:0] WBX_PcPlus4M,
  input  logic [REGW-1:0]  WBX_WriteRegM,
  input  logic             WBX_RegWriteM,
  input  logic [1:0]       WBX_ResultSrcM,
  input  logic [1:0]       WBX_LoadSizeM,
  input  logic             WBX_LoadUnsM,
  input  logic             WBX_FlushM,
  output logic [WIDTH-1:0] WBX_ResultW,
  output logic [REGW-1:0]  WBX_WriteRegW,
  output logic             WBX_RegWriteW,
  output logic             WBX_StallM,
  output logic             WBX_LoadErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [REGW-1:0]  write_reg_q, write_reg_d;
  logic             reg_write_q, reg_write_d;
  logic [1:0]       result_src_q, result_src_d;
  logic [WIDTH-1:0] load_fmt;
  logic             pending, timeout;

  assign pending    = WBX_RegWriteM && (WBX_ResultSrcM == SRC_LOAD) && !WBX_ReadValidM && !WBX_FlushM;
  assign timeout    = pending && (state_q == ST_WAIT) && (count_q == CW'(TIMEOUT));
  assign WBX_StallM = pending && !timeout;

  always_comb begin
    state_d      = ST_IDLE;
    count_d      = '0;
    load_err_d   = load_err_q;
    alu_out_d    = WBX_AluOutM;
    read_data_d  = WBX_ReadDataM;
    pc_plus4_d   = WBX_PcPlus4M;
    write_reg_d  = WBX_WriteRegM;
    reg_write_d  = WBX_RegWriteM;
    result_src_d = WBX_ResultSrcM;
    if (WBX_FlushM) begin
      reg_write_d = 1'b0;
    end else if (timeout) begin
      // hung load retires with zero data so the pipeline can move on
      read_data_d = '0;
      load_err_d  = 1'b1;
    end else if (pending) begin
      reg_write_d = 1'b0;
      state_d     = ST_WAIT;
      count_d     = count_q + CW'(1);
    end
  end

  always_ff @(posedge WBX_CLK) begin
    if (WBX_RST) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      load_err_q   <= 1'b0;
      alu_out_q    <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      load_err_q   <= load_err_d;
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
    end
  end

`ifdef WBX_SUBWORD_LOAD_EN
  logic [1:0] load_size_q, load_size_d;
  logic       load_uns_q, load_uns_d;

  assign load_size_d = WBX_LoadSizeM;
  assign load_uns_d  = WBX_LoadUnsM;

  always_ff @(posedge WBX_CLK) begin
    if (WBX_RST) begin
      load_size_q <= '0;
      load_uns_q  <= 1'b0;
    end else begin
      load_size_q <= load_size_d;
      load_uns_q  <= load_uns_d;
    end
  end

  wbx_load_align #(.WIDTH(WIDTH)) u_align (
    .data_i  (read_data_q),
    .offset_i(alu_out_q[1:0]),
    .size_i  (load_size_q),
    .uns_i   (load_uns_q),
    .data_o  (load_fmt)
  );
`else
  logic unused_load_cfg;
  assign unused_load_cfg = ^{WBX_LoadSizeM, WBX_LoadUnsM};
  assign load_fmt        = read_data_q;
`endif

  always_comb begin
    case (result_src_q)
      SRC_LOAD: WBX_ResultW = load_fmt;
      SRC_LINK: WBX_ResultW = pc_plus4_q;
      default:  WBX_ResultW = alu_out_q;
    endcase
  end

  assign WBX_WriteRegW = write_reg_q;
  assign WBX_RegWriteW = reg_write_q;
  assign WBX_LoadErr   = load_err_q;

endmodule

// File: tb/tb_writeback_ext.sv
// Self-checking bench for writeback_ext: directed cases plus randomized traffic vs. a behavioural model.
module tb_writeback_ext;

  localparam int TIMEOUT = 4;
`ifdef WBX_SUBWORD_LOAD_EN
  localparam bit SUBW = 1'b1;
`else
  localparam bit SUBW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, rdata, pc;
  logic        valid, rw, uns, flush;
  logic [4:0]  wreg;
  logic [1:0]  src, size;
  logic [31:0] result_w;
  logic [4:0]  wreg_w;
  logic        rw_w, stall, load_err;

  int checks = 0;
  int errors = 0;

  // model state: what W should hold, sticky error, consecutive stall cycles of current load
  bit          m_valid, m_err, exp_stall;
  logic [31:0] m_res;
  logic [4:0]  m_reg;
  int          m_wait;

  always #5 clk = ~clk;

  writeback_ext #(.WIDTH(32), .REGW(5), .TIMEOUT(TIMEOUT)) dut (
    .WBX_CLK(clk), .WBX_RST(rst), .WBX_AluOutM(alu), .WBX_ReadDataM(rdata),
    .WBX_ReadValidM(valid), .WBX_PcPlus4M(pc), .WBX_WriteRegM(wreg),
    .WBX_RegWriteM(rw), .WBX_ResultSrcM(src), .WBX_LoadSizeM(size),
    .WBX_LoadUnsM(uns), .WBX_FlushM(flush), .WBX_ResultW(result_w),
    .WBX_WriteRegW(wreg_w), .WBX_RegWriteW(rw_w), .WBX_StallM(stall),
    .WBX_LoadErr(load_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                                      input logic [31:0] p, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (s == 2'd2) return p;
    if (s != 2'd1) return a;
    if (SUBW && sz == 2'd0) begin
      v = (d >> (8 * a[1:0])) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (SUBW && sz == 2'd1) begin
      v = (d >> (16 * a[1])) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return d;
  endfunction

  // inputs are stable from the preceding negedge; compare, then advance model at posedge
  task automatic cycle();
    bit pend, tmo;
    #1;
    pend = rw && (src == 2'd1) && !valid && !flush;
    tmo  = pend && (m_wait == TIMEOUT);
    exp_stall = pend && !tmo;
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("regwrite_w", {31'd0, rw_w}, {31'd0, m_valid});
    if (m_valid) begin
      chk("result_w", result_w, m_res);
      chk("writereg_w", {27'd0, wreg_w}, {27'd0, m_reg});
    end
    chk("load_err", {31'd0, load_err}, {31'd0, m_err});
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_err = 0; m_wait = 0; m_res = 0; m_reg = 0;
    end else if (flush) begin
      m_valid = 0; m_wait = 0;
    end else if (exp_stall) begin
      m_valid = 0; m_wait++;
    end else begin
      m_valid = rw;
      m_reg   = wreg;
      m_res   = fmt(src, alu, tmo ? 32'd0 : rdata, pc, size, uns);
      m_wait  = 0;
      if (tmo) m_err = 1;
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                        input logic v, input logic [1:0] sz, input logic u, input logic [4:0] r);
    rw = 1; src = s; alu = a; rdata = d; valid = v; size = sz; uns = u; wreg = r; flush = 0;
    pc = 32'h0040_0010;
  endtask

  initial begin
    rst = 1; alu = 0; rdata = 0; valid = 1; pc = 0; wreg = 0; rw = 0; src = 0;
    size = 0; uns = 0; flush = 0;
    m_valid = 0; m_err = 0; m_wait = 0; m_res = 0; m_reg = 0; exp_stall = 0;
    @(negedge clk);
    cycle(); cycle();
    rst = 0;
    chk("rst_result", result_w, 32'd0);
    chk("rst_wreg", {27'd0, wreg_w}, 32'd0);
    chk("rst_rw", {31'd0, rw_w}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);

    set_op(2'd0, 32'h0000_1234, 32'h0, 1, 2'd2, 0, 5'd8);
    cycle();
    chk("alu_result", result_w, 32'h0000_1234);
    chk("alu_wreg", {27'd0, wreg_w}, 32'd8);
    chk("alu_rw", {31'd0, rw_w}, 32'd1);

    set_op(2'd1, 32'h1000_0003, 32'h80FF_7F01, 1, 2'd0, 0, 5'd9);
    cycle();
    chk("lb_signed", result_w, SUBW ? 32'hFFFF_FF80 : 32'h80FF_7F01);
    uns = 1;
    cycle();
    chk("lb_unsigned", result_w, SUBW ? 32'h0000_0080 : 32'h80FF_7F01);
    set_op(2'd1, 32'h1000_0002, 32'h8001_7FFF, 1, 2'd1, 0, 5'd10);
    cycle();
    chk("lh_signed", result_w, SUBW ? 32'hFFFF_8001 : 32'h8001_7FFF);
    set_op(2'd2, 32'h0, 32'h0, 1, 2'd2, 0, 5'd31);
    cycle();
    chk("link", result_w, 32'h0040_0010);

    // load late by 3 cycles
    set_op(2'd1, 32'h1000_0000, 32'h0, 0, 2'd2, 0, 5'd11);
    for (int i = 0; i < 3; i++) begin
      #1 chk("late_stall", {31'd0, stall}, 32'd1);
      cycle();
      chk("late_bubble", {31'd0, rw_w}, 32'd0);
    end
    valid = 1; rdata = 32'hDEAD_BEEF;
    #1 chk("late_stall_off", {31'd0, stall}, 32'd0);
    cycle();
    chk("late_result", result_w, 32'hDEAD_BEEF);
    chk("late_rw", {31'd0, rw_w}, 32'd1);

    // timeout: data never arrives
    set_op(2'd1, 32'h1000_0000, 32'h1234_5678, 0, 2'd2, 0, 5'd12);
    for (int i = 0; i < TIMEOUT; i++) begin
      #1 chk("to_stall", {31'd0, stall}, 32'd1);
      cycle();
    end
    #1 chk("to_stall_off", {31'd0, stall}, 32'd0);
    cycle();
    chk("to_result", result_w, 32'd0);
    chk("to_rw", {31'd0, rw_w}, 32'd1);
    chk("to_err", {31'd0, load_err}, 32'd1);
    set_op(2'd0, 32'h55, 32'h0, 1, 2'd2, 0, 5'd1);
    cycle(); cycle();
    chk("err_sticky", {31'd0, load_err}, 32'd1);
    rst = 1;
    cycle();
    rst = 0;
    chk("err_cleared", {31'd0, load_err}, 32'd0);

    // flush on second stall cycle
    set_op(2'd1, 32'h1000_0000, 32'h0, 0, 2'd2, 0, 5'd13);
    cycle();
    flush = 1;
    #1 chk("flush_stall", {31'd0, stall}, 32'd0);
    cycle();
    chk("flush_bubble", {31'd0, rw_w}, 32'd0);
    flush = 0;
    for (int i = 0; i < TIMEOUT; i++) cycle();
    #1 chk("flush_recount", {31'd0, stall}, 32'd0);
    cycle();

    // reset in the middle of a wait
    set_op(2'd1, 32'h1000_0000, 32'h0, 0, 2'd2, 0, 5'd14);
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0; rw = 0; valid = 1;
    chk("rstw_result", result_w, 32'd0);
    chk("rstw_wreg", {27'd0, wreg_w}, 32'd0);
    chk("rstw_rw", {31'd0, rw_w}, 32'd0);
    cycle();

    for (int n = 0; n < 800; n++) begin
      if (!exp_stall) begin
        rw    = ($urandom_range(0, 3) != 0);
        src   = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
        alu   = $urandom;
        pc    = $urandom;
        wreg  = 5'($urandom);
        size  = 2'($urandom);
        uns   = 1'($urandom);
      end
      rdata = $urandom;
      valid = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_ext.md
# writeback_ext

Parametrised write-back stage for the 5-stage pipelined MIPS, the next generation of the existing M→W stage. It registers Memory-stage results into the W pipeline register, then selects among ALU result, formatted load data and link address (PC+4). Sub-word loads are aligned and sign- or zero-extended. The block stalls the pipeline while a load's memory data is late, and a watchdog turns a hung load into a logged error.

## Interface
- WIDTH, 32: datapath width; must be ≥ 32 and a multiple of 8.
- REGW, 5: register-address width.
- TIMEOUT, 15: maximum cycles to wait for load data; ≥ 1.
- WBX_CLK  in  1  clock, rising edge.
- WBX_RST  in  1  synchronous, active-high reset.
- WBX_AluOutM  in  WIDTH  ALU result or load address; bits [1:0] give the byte offset.
- WBX_ReadDataM  in  WIDTH  raw memory word.
- WBX_ReadValidM  in  1  WBX_ReadDataM is valid this cycle.
- WBX_PcPlus4M  in  WIDTH  link value for JAL/JALR.
- WBX_WriteRegM  in  REGW  destination register.
- WBX_RegWriteM  in  1  instruction writes the register file.
- WBX_ResultSrcM  in  2  result source: 00 ALU, 01 LOAD, 10 LINK, 11 reserved (treated as ALU).
- WBX_LoadSizeM  in  2  load size: 00 byte, 01 half, 10 word, 11 treated as word.
- WBX_LoadUnsM  in  1  1 = zero-extend, 0 = sign-extend.
- WBX_FlushM  in  1  kill the M-stage instruction.
- WBX_ResultW  out  WIDTH  write-back data.
- WBX_WriteRegW  out  REGW  write-back register.
- WBX_RegWriteW  out  1  write-back enable.
- WBX_StallM  out  1  hold the F/D/E/M stages this cycle.
- WBX_LoadErr  out  1  sticky; set when a load times out.

## Operation
- **Pending load.** A pending load exists when RegWriteM=1, ResultSrcM=LOAD, ReadValidM=0 and FlushM=0.
- **StallM.** Combinational: StallM = pending load. It is asserted in the same cycle the condition holds.
- **W register update, every edge:**
  - FlushM=1: capture a bubble (RegWriteW←0). Other fields are don't-care.
  - Else, pending load: capture a bubble.
  - Else: capture all M fields plus AluOutM[1:0] and ReadDataM.
- **FSM states: IDLE, WAIT.**
  - IDLE→WAIT when a load is pending; count←1.
  - WAIT→WAIT while still pending and count<TIMEOUT; count+1.
  - WAIT→IDLE when ReadValidM=1. The load is captured normally.
  - WAIT→IDLE when count=TIMEOUT while still pending. The load is captured with ReadDataM forced to 0, and LoadErr←1. StallM is deasserted in that cycle.
  - WAIT→IDLE on FlushM=1. A bubble is captured and the count is cleared.
- **Result select** (combinational from the W register):
  - ALU → AluOutW.
  - LINK → PcPlus4W.
  - LOAD → formatted data:
    - byte: lane selected by offset (little-endian), extended to WIDTH.
    - half: lane selected by offset[1]; offset[0] is ignored.
    - word: the raw word.
- **Reset** (synchronous, any state including WAIT): FSM=IDLE, count=0, LoadErr=0, all W register fields=0.
  - Outputs after reset: ResultW=0, WriteRegW=0, RegWriteW=0, StallM=0 unless a load is pending at the inputs.
- **LoadErr** clears only on reset.

## Timing
- Latency M→W: one cycle. ResultW is valid in the cycle after capture.
- A load whose data arrives k cycles late (k < TIMEOUT) reaches W after k+1 cycles. Bubbles fill W meanwhile.
- When a timeout occurs, StallM is high for exactly TIMEOUT cycles.
- FlushM overrides both the stall and the timeout in the same cycle.

## Configuration
- WBX_SUBWORD_LOAD_EN defined: byte and half formatting as described above.
- WBX_SUBWORD_LOAD_EN undefined:
  - LoadSizeM and LoadUnsM are ignored, and LOAD returns the raw word.
  - The align sub-module is not instantiated.
  - Stall, FSM and timeout behaviour are unchanged.

## Structure
- Shared package wbx_pkg holds:
  - ResultSrc encodings (SRC_ALU, SRC_LOAD, SRC_LINK).
  - LoadSize encodings (LD_BYTE, LD_HALF, LD_WORD).
  - FSM state encoding (ST_IDLE, ST_WAIT).
- One sub-module, wbx_load_align: combinational lane select plus extension, parametrised by WIDTH.
- The W register, FSM, counter (width $clog2(TIMEOUT+1)) and result mux live in the top level.

## Test plan
- ALU op: AluOutM=0x0000_1234, WriteRegM=8, RegWriteM=1 → next cycle ResultW=0x0000_1234, WriteRegW=8, RegWriteW=1, StallM=0 throughout.
- Signed byte: ReadDataM=0x80FF_7F01, AluOutM[1:0]=3, size=byte, Uns=0 → ResultW=0xFFFF_FF80. Same with Uns=1 → 0x0000_0080.
- Half: ReadDataM=0x8001_7FFF, offset=2, signed → 0xFFFF_8001. With WBX_SUBWORD_LOAD_EN undefined → 0x8001_7FFF.
- Late load: ReadValidM low for 3 cycles, then high with 0xDEAD_BEEF → StallM high for 3 cycles, RegWriteW=0 during them, then ResultW=0xDEAD_BEEF one cycle after valid.
- Timeout with TIMEOUT=4: ReadValidM held low → StallM high for 4 cycles, then ResultW=0, RegWriteW=1, LoadErr=1 and sticky. A subsequent WBX_RST clears LoadErr.
- Flush in WAIT: FlushM=1 on the 2nd stall cycle → StallM=0 that cycle, bubble captured (RegWriteW=0), FSM returns to IDLE. Reset asserted mid-WAIT → all outputs 0 on the next cycle.
